// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-byte holding register ahead of the shifter.
module uart_tx #(
    parameter int CLK_FREQ_HZ = 10000000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] DATA,
    input  logic       VALID,
    output logic       READY,
    output logic       TXD,
    output logic       BUSY
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW = CLKS_PER_BIT < 2 ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_rate_check
        $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state;
    logic [7:0]    hold;
    logic [7:0]    shift;
    logic          hold_full;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          last;

    assign last  = cnt == LAST;
    assign READY = RESET && !hold_full;

    // TXD and BUSY are registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= S_IDLE;
            TXD       <= 1'b1;
            BUSY      <= 1'b0;
            hold_full <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
        end else begin
            TXD  <= state == S_START ? 1'b0 : state == S_DATA ? shift[idx] : 1'b1;
            BUSY <= state != S_IDLE || hold_full;
            if (VALID && !hold_full) begin
                hold      <= DATA;
                hold_full <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (hold_full) begin
                        shift     <= hold;
                        hold_full <= 1'b0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    cnt <= last ? '0 : cnt + CW'(1);
                    if (last) state <= S_DATA;
                end
                S_DATA: begin
                    cnt <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= S_STOP;
                    end
                end
                default: begin
                    cnt <= last ? '0 : cnt + CW'(1);
                    if (last && hold_full) begin
                        shift     <= hold;
                        hold_full <= 1'b0;
                        state     <= S_START;
                    end else if (last) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random checks of uart_tx against a frame-level model and a line decoder.
module tb_uart_tx;
    localparam int C = 4;
    localparam int F = 10 * C;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] DATA = 8'h00;
    logic       VALID = 1'b0;
    logic       READY, TXD, BUSY;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    logic [7:0] acc_q[$];
    int         starts[$];
    bit         rx_on = 1'b0;
    int         rx_ph = 0;
    logic [7:0] rx_b;

    uart_tx #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(250000)) dut (
        .CLK(CLK), .RESET(RESET), .DATA(DATA), .VALID(VALID),
        .READY(READY), .TXD(TXD), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
    endfunction

    // Handshakes as seen on the bus; a reset discards anything accepted.
    always @(posedge CLK) begin
        if (!RESET) acc_q.delete();
        else if (VALID && READY) acc_q.push_back(DATA);
    end

    // Line decoder: sample mid-bit, abort on reset.
    always @(negedge CLK) begin
        if (!RESET) rx_on = 1'b0;
        else if (!rx_on) begin
            if (TXD == 1'b0) begin
                rx_on = 1'b1;
                rx_ph = 0;
                starts.push_back(cyc);
            end
        end else begin
            rx_ph++;
            if (rx_ph % C == C / 2) begin
                if (rx_ph / C == 0) chk("start_bit", TXD, 0);
                else if (rx_ph / C < 9) rx_b[rx_ph/C-1] = TXD;
                else begin
                    chk("stop_bit", TXD, 1);
                    rx_q.push_back(rx_b);
                    rx_on = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        rx_q.delete();
        acc_q.delete();
        starts.delete();
    endtask

    task automatic drain();
        int t = 0;
        repeat (3) tick();
        while ((BUSY || TXD !== 1'b1) && t < 2000) begin
            tick();
            t++;
        end
        chk("drain_done", t < 2000, 1);
        repeat (2) tick();
    endtask

    initial begin
        logic [7:0] b3[3];
        int         lows;
        int         busys;
        int         i;
        bit         rdy;
        b3[0] = 8'h55; b3[1] = 8'h33; b3[2] = 8'h0F;

        // reset state
        repeat (3) tick();
        chk("rst_txd", TXD, 1);
        chk("rst_ready", READY, 0);
        chk("rst_busy", BUSY, 0);
        RESET = 1'b1;
        #1;
        chk("ready_on_release", READY, 1);
        clr();

        // single byte 0xA5, accepted on first edge after release
        VALID = 1'b1;
        DATA = 8'hA5;
        tick();
        VALID = 1'b0;
        chk("t1_ready_after_acc", READY, 0);
        for (int k = 1; k <= 43; k++) begin
            tick();
            chk("t1_txd", TXD, (k < 2 || k >= 2 + F) ? 1'b1 : frame_bit(8'hA5, (k - 2) / C));
            chk("t1_busy", BUSY, k < 2 + F);
        end
        chk("t1_rx_count", rx_q.size(), 1);
        if (rx_q.size() == 1) chk("t1_rx_byte", rx_q[0], 8'hA5);

        // back-to-back 0x00 then 0xFF with VALID held
        clr();
        VALID = 1'b1;
        DATA = 8'h00;
        tick();
        chk("t2_ready_k0", READY, 0);
        DATA = 8'hFF;
        for (int k = 1; k <= 85; k++) begin
            tick();
            if (k == 2) VALID = 1'b0;
            chk("t2_txd", TXD, (k < 2 || k >= 2 + 2 * F) ? 1'b1 :
                frame_bit(k < 2 + F ? 8'h00 : 8'hFF, ((k - 2) % F) / C));
            chk("t2_ready", READY, (k == 1 || k > F) ? 1 : 0);
            chk("t2_busy", BUSY, k < 2 + 2 * F);
        end
        chk("t2_starts", starts.size(), 2);
        if (starts.size() == 2) chk("t2_gap", starts[1] - starts[0], F);
        chk("t2_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("t2_rx0", rx_q[0], 8'h00);
            chk("t2_rx1", rx_q[1], 8'hFF);
        end

        // backpressure with three bytes
        clr();
        i = 0;
        VALID = 1'b1;
        DATA = b3[0];
        for (int t = 0; t < 300 && i < 3; t++) begin
            rdy = READY;
            tick();
            if (rdy) begin
                i++;
                chk("t3_ready_after_acc", READY, 0);
                if (i < 3) DATA = b3[i];
                else VALID = 1'b0;
            end
        end
        VALID = 1'b0;
        chk("t3_all_accepted", i, 3);
        drain();
        chk("t3_rx_count", rx_q.size(), 3);
        for (int k = 0; k < 3 && k < rx_q.size(); k++) chk("t3_rx_byte", rx_q[k], b3[k]);
        chk("t3_starts", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("t3_gap01", starts[1] - starts[0], F);
            chk("t3_gap12", starts[2] - starts[1], F);
        end

        // reset during data bit 3 of 0xC3 with 0x5A held
        clr();
        VALID = 1'b1;
        DATA = 8'hC3;
        tick();
        DATA = 8'h5A;
        tick();
        tick();
        VALID = 1'b0;
        chk("t4_held", READY, 0);
        repeat (16) tick();
        chk("t4_bit3", TXD, 0);
        RESET = 1'b0;
        tick();
        chk("t4_rst_txd", TXD, 1);
        chk("t4_rst_ready", READY, 0);
        chk("t4_rst_busy", BUSY, 0);
        tick();
        RESET = 1'b1;
        #1;
        chk("t4_ready_release", READY, 1);
        lows = 0;
        busys = 0;
        repeat (100) begin
            tick();
            if (TXD !== 1'b1) lows++;
            if (BUSY !== 1'b0) busys++;
        end
        chk("t4_txd_low_cycles", lows, 0);
        chk("t4_busy_cycles", busys, 0);
        chk("t4_rx_count", rx_q.size(), 0);

        // VALID toggling while the holding register is full
        clr();
        VALID = 1'b1;
        DATA = 8'h96;
        tick();
        DATA = 8'h3C;
        tick();
        tick();
        for (int k = 3; k <= 38; k++) begin
            VALID = 1'($urandom_range(0, 1));
            DATA = 8'($urandom);
            tick();
            chk("t5_ready_low", READY, 0);
        end
        VALID = 1'b0;
        drain();
        chk("t5_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("t5_rx0", rx_q[0], 8'h96);
            chk("t5_rx1", rx_q[1], 8'h3C);
        end

        // random traffic: every accepted byte must appear on the line, in order
        clr();
        for (int t = 0; t < 1500; t++) begin
            VALID = $urandom_range(0, 3) == 0;
            DATA = 8'($urandom);
            tick();
        end
        VALID = 1'b0;
        drain();
        chk("rnd_nonempty", acc_q.size() > 5, 1);
        chk("rnd_count", rx_q.size(), acc_q.size());
        for (int k = 0; k < rx_q.size() && k < acc_q.size(); k++) chk("rnd_byte", rx_q[k], acc_q[k]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 10000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate in bits/s.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge; the design has one clock.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port DATA  input  8  byte to transmit, sampled on handshake.
REQ-006 SHALL have port VALID  input  1  producer asserts while DATA holds a byte to send.
REQ-007 SHALL have port READY  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port TXD  output  1  serial line, idle high, registered.
REQ-009 SHALL have port BUSY  output  1  high while a frame is in progress or a byte is buffered.

Function
REQ-010 SHALL define CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE with integer truncation (default 86); elaboration SHALL fail if CLKS_PER_BIT < 2.
REQ-011 SHALL transmit 8N1 frames: start bit 0, DATA[0]..DATA[7] LSB first, stop bit 1.
REQ-012 SHALL hold every bit, including start and stop, on TXD for exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-013 SHALL contain a one-byte holding register (hold_full flag) plus a shift register; READY = !hold_full while RESET is high; READY = 0 while RESET is low.
REQ-014 SHALL accept a byte on a rising edge where VALID && READY: DATA goes to the holding register and hold_full is set.
REQ-015 SHALL allow VALID to be asserted or dropped freely; no transfer SHALL occur without READY high; READY SHALL NOT depend combinationally on VALID.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP; baud counter 0..CLKS_PER_BIT-1; bit index 0..7.
REQ-017 IDLE: TXD=1; if hold_full, next edge SHALL move holding->shift register, clear hold_full, enter START.
REQ-018 START: TXD=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-019 DATA: TXD=shift bit [index]; after CLKS_PER_BIT cycles increment index; after index 7 enter STOP.
REQ-020 STOP: TXD=1 for CLKS_PER_BIT cycles; on the final cycle, if hold_full, SHALL go directly to START loading the holding byte (no idle gap); else IDLE.
REQ-021 Latency: handshake on edge E with FSM in IDLE and hold empty -> TXD low from edge E+2 (one cycle in IDLE with hold_full).
REQ-022 While a frame is in progress with hold empty, READY SHALL be high and one further byte SHALL be accepted; READY then stays low until that byte is moved to the shift register.
REQ-023 BUSY = (state != IDLE) || hold_full.
REQ-024 Baud counter and bit index SHALL reset to 0 on every state entry.

Reset
REQ-025 On any rising edge with RESET low: state=IDLE, TXD=1, hold_full=0, counters=0; READY=0, BUSY=0.
REQ-026 Reset mid-frame SHALL abort the frame immediately (TXD=1 from that edge) and discard the shifting and held bytes.
REQ-027 First accept possible on the first edge after RESET returns high (READY=1 in that cycle).

Verification (CLK_FREQ_HZ=1000000, BAUD_RATE=250000 -> CLKS_PER_BIT=4)
REQ-028 Single byte: accept 0xA5 at edge E -> TXD low edges E+2..E+5, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; BUSY falls at E+42; no idle gap inside frame.
REQ-029 Back-to-back: send 0x00 then 0xFF with VALID held high -> second accepted one cycle after the first moves to the shifter; READY low for the remainder; stop bit of frame 1 followed immediately by start bit of frame 2; 80 cycles total from the first start bit.
REQ-030 Backpressure: VALID held high with 0x55, 0x33, 0x0F -> exactly three frames in order, no byte lost or duplicated; READY never high while hold_full.
REQ-031 Reset mid-frame: assert RESET low during bit 3 of 0xC3 with a second byte held -> TXD=1, READY=0, BUSY=0 on that edge; no frame emitted after release until a new handshake.
REQ-032 VALID without READY: toggle VALID with varying DATA during a frame with hold full -> holding byte unchanged; the transmitted byte equals the one accepted.
